// File: rtl/aurora_64b66b_25p78g_qpll_reset_seq.sv
// ---------------------------------------------------------------------------
// aurora_64b66b_25p78g_qpll_reset_seq
//
// Reset/lock sequencer for the GT common QPLL0. It holds qpll0_reset for a
// fixed number of cycles, then waits for lock. Lock must stay stable for a
// qualification window before pll_ready is raised. A lock timeout retries the
// QPLL. After MAX_RETRIES timeouts the sequencer parks in FAIL with the QPLL
// held in reset. pll_ready gates channel TX/RX reset release downstream.
//
// Ports:
//   init_clk          in   free-running init clock, sole clock
//   reset_n           in   synchronous active-low reset
//   pll_reset_req     in   request to restart the sequence (priority over FSM)
//   qpll0_lock        in   QPLL0 lock, asynchronous, synchronised here
//   qpll0_refclklost  in   QPLL0 refclk lost, asynchronous, synchronised here
//   qpll0_reset       out  QPLL0 reset (high in RST_ASSERT and FAIL)
//   pll_ready         out  QPLL0 locked and stable (READY)
//   pll_fail          out  retries exhausted (FAIL)
//   retry_count [3:0] out  lock timeouts in the current sequence
//   seq_state   [2:0] out  state encoding, debug only
// ---------------------------------------------------------------------------
module aurora_64b66b_25p78g_qpll_reset_seq #(
    parameter int RESET_HOLD_CYCLES   = 128,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES         = 4,
    parameter int CNT_WIDTH           = 20
) (
    input  logic       init_clk,
    input  logic       reset_n,
    input  logic       pll_reset_req,
    input  logic       qpll0_lock,
    input  logic       qpll0_refclklost,
    output logic       qpll0_reset,
    output logic       pll_ready,
    output logic       pll_fail,
    output logic [3:0] retry_count,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        ST_RST_ASSERT  = 3'd0,
        ST_WAIT_LOCK   = 3'd1,
        ST_LOCK_STABLE = 3'd2,
        ST_READY       = 3'd3,
        ST_FAIL        = 3'd4
    } state_e;

    // Terminal counts: the counter runs 0..N-1, so N cycles per phase.
    localparam logic [CNT_WIDTH-1:0] HOLD_LAST    = CNT_WIDTH'(RESET_HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] STABLE_LAST  = CNT_WIDTH'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]           RETRY_LIMIT  = 4'(MAX_RETRIES);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

    // Two-flop synchronisers for the asynchronous GT common status.
    logic lock_meta_q, lock_meta_d;
    logic lock_s_q,    lock_s_d;
    logic lost_meta_q, lost_meta_d;
    logic lost_s_q,    lost_s_d;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;
    logic [3:0]           retry_q, retry_d;

    logic qpll0_reset_q, qpll0_reset_d;
    logic pll_ready_q,   pll_ready_d;
    logic pll_fail_q,    pll_fail_d;

    always_comb begin
        lock_meta_d = qpll0_lock;
        lock_s_d    = lock_meta_q;
        lost_meta_d = qpll0_refclklost;
        lost_s_d    = lost_meta_q;
    end

    // Next-state logic.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;

        if (pll_reset_req) begin
            state_d = ST_RST_ASSERT;
            cnt_d   = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                ST_RST_ASSERT: begin
                    // Do not start timing the reset pulse until the refclk is
                    // back; the QPLL needs a full hold with a clock present.
                    if (lost_s_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_WAIT_LOCK: begin
                    if (lost_s_q) begin
                        state_d = ST_RST_ASSERT;
                        cnt_d   = '0;
                    end else if (lock_s_q) begin
                        state_d = ST_LOCK_STABLE;
                        cnt_d   = '0;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        retry_d = retry_q + 4'd1;
                        cnt_d   = '0;
                        // FAIL is entered at the limit, so retry never wraps.
                        state_d = (retry_d == RETRY_LIMIT) ? ST_FAIL : ST_RST_ASSERT;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_LOCK_STABLE: begin
                    if (lost_s_q) begin
                        state_d = ST_RST_ASSERT;
                        cnt_d   = '0;
                    end else if (!lock_s_q) begin
                        // A lock glitch is not a timeout: rewait without
                        // charging a retry.
                        state_d = ST_WAIT_LOCK;
                        cnt_d   = '0;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end

                ST_READY: begin
                    // Losing lock after READY starts a fresh sequence.
                    if (!lock_s_q || lost_s_q) begin
                        state_d = ST_RST_ASSERT;
                        cnt_d   = '0;
                        retry_d = '0;
                    end
                end

                ST_FAIL: begin
                    // Terminal until pll_reset_req or reset_n.
                end

                default: begin
                    state_d = ST_RST_ASSERT;
                    cnt_d   = '0;
                    retry_d = '0;
                end
            endcase
        end

        // Outputs decode the next state so they register on the same edge
        // as the state change.
        qpll0_reset_d = (state_d == ST_RST_ASSERT) || (state_d == ST_FAIL);
        pll_ready_d   = (state_d == ST_READY);
        pll_fail_d    = (state_d == ST_FAIL);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge init_clk) begin
        if (!reset_n) begin
            lock_meta_q   <= 1'b0;
            lock_s_q      <= 1'b0;
            lost_meta_q   <= 1'b0;
            lost_s_q      <= 1'b0;
            state_q       <= ST_RST_ASSERT;
            cnt_q         <= '0;
            retry_q       <= '0;
            qpll0_reset_q <= 1'b1;
            pll_ready_q   <= 1'b0;
            pll_fail_q    <= 1'b0;
        end else begin
            lock_meta_q   <= lock_meta_d;
            lock_s_q      <= lock_s_d;
            lost_meta_q   <= lost_meta_d;
            lost_s_q      <= lost_s_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            retry_q       <= retry_d;
            qpll0_reset_q <= qpll0_reset_d;
            pll_ready_q   <= pll_ready_d;
            pll_fail_q    <= pll_fail_d;
        end
    end

    assign qpll0_reset = qpll0_reset_q;
    assign pll_ready   = pll_ready_q;
    assign pll_fail    = pll_fail_q;
    assign retry_count = retry_q;
    assign seq_state   = state_q;

endmodule

// File: tb/tb_aurora_64b66b_25p78g_qpll_reset_seq.sv
// ---------------------------------------------------------------------------
// Testbench for aurora_64b66b_25p78g_qpll_reset_seq.
// Parameters: RESET_HOLD=8, TIMEOUT=64, STABLE=16, MAX_RETRIES=3.
// Inputs are driven and outputs sampled on the falling edge of init_clk.
// ---------------------------------------------------------------------------
module tb_aurora_64b66b_25p78g_qpll_reset_seq;

    logic       init_clk = 1'b0;
    logic       reset_n;
    logic       pll_reset_req;
    logic       qpll0_lock;
    logic       qpll0_refclklost;
    logic       qpll0_reset;
    logic       pll_ready;
    logic       pll_fail;
    logic [3:0] retry_count;
    logic [2:0] seq_state;

    always #5 init_clk = ~init_clk;

    aurora_64b66b_25p78g_qpll_reset_seq #(
        .RESET_HOLD_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES(64),
        .LOCK_STABLE_CYCLES (16),
        .MAX_RETRIES        (3),
        .CNT_WIDTH          (8)
    ) dut (
        .init_clk        (init_clk),
        .reset_n         (reset_n),
        .pll_reset_req   (pll_reset_req),
        .qpll0_lock      (qpll0_lock),
        .qpll0_refclklost(qpll0_refclklost),
        .qpll0_reset     (qpll0_reset),
        .pll_ready       (pll_ready),
        .pll_fail        (pll_fail),
        .retry_count     (retry_count),
        .seq_state       (seq_state)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        bit         do_reset;
        logic       lock;
        logic       lost;
        logic       req;
        int         cycles;
        logic       e_rst;
        logic       e_rdy;
        logic       e_fail;
        logic [3:0] e_retry;
        logic [2:0] e_state;
    } vec_t;

    typedef struct {
        string      name;
        logic       rst;
        logic       rdy;
        logic       fail;
        logic [3:0] retry;
        logic [2:0] state;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    // Rising edges of qpll0_reset, used to spot unwanted extra reset pulses.
    int   rst_rises = 0;
    logic prev_rst  = 1'b1;
    always @(negedge init_clk) begin
        if (qpll0_reset === 1'b1 && prev_rst === 1'b0) rst_rises++;
        prev_rst = qpll0_reset;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge init_clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic sb_push(input string name, input logic rst, input logic rdy,
                           input logic fail, input int retry, input int state);
        exp_t e;
        e.name  = name;
        e.rst   = rst;
        e.rdy   = rdy;
        e.fail  = fail;
        e.retry = 4'(retry);
        e.state = 3'(state);
        sb.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: got no expected entry, required one");
        end else begin
            e = sb.pop_front();
            if (qpll0_reset !== e.rst || pll_ready !== e.rdy || pll_fail !== e.fail ||
                retry_count !== e.retry || seq_state !== e.state) begin
                bad++;
                $display("FAIL %s: got rst=%0b rdy=%0b fail=%0b retry=%0d state=%0d, required rst=%0b rdy=%0b fail=%0b retry=%0d state=%0d",
                         e.name, qpll0_reset, pll_ready, pll_fail, retry_count, seq_state,
                         e.rst, e.rdy, e.fail, e.retry, e.state);
            end
        end
    endtask

    // Push the expectation, run n cycles, compare.
    task automatic step_expect(input string name, input int n, input logic rst,
                               input logic rdy, input logic fail, input int retry,
                               input int state);
        sb_push(name, rst, rdy, fail, retry, state);
        tick(n);
        sb_pop_check();
    endtask

    // Two reset edges; returns on the falling edge before the first active edge.
    task automatic apply_reset(input logic lock, input logic lost);
        reset_n          = 1'b0;
        pll_reset_req    = 1'b0;
        qpll0_lock       = lock;
        qpll0_refclklost = lost;
        tick(2);
        reset_n = 1'b1;
    endtask

    // Cycles until qpll0_reset falls, bounded by max.
    task automatic cycles_until_reset_low(input int max, output int n);
        n = 0;
        while (qpll0_reset === 1'b1 && n < max) begin
            tick(1);
            n++;
        end
    endtask

    function automatic vec_t mk(input string n, input bit r, input logic lk,
                                input logic ls, input logic rq, input int c,
                                input logic er, input logic ed, input logic ef,
                                input int et, input int es);
        vec_t v;
        v.name     = n;
        v.do_reset = r;
        v.lock     = lk;
        v.lost     = ls;
        v.req      = rq;
        v.cycles   = c;
        v.e_rst    = er;
        v.e_rdy    = ed;
        v.e_fail   = ef;
        v.e_retry  = 4'(et);
        v.e_state  = 3'(es);
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int low_cycles;
        int rise0;

        reset_n          = 1'b0;
        pll_reset_req    = 1'b0;
        qpll0_lock       = 1'b0;
        qpll0_refclklost = 1'b0;
        tick(1);

        // name, reset, lock, lost, req, cycles -> rst, rdy, fail, retry, state
        // Bring-up: 8-cycle hold, lock 20 cycles later, ready 19 edges after lock.
        vecs.push_back(mk("t1_reset_state", 1, 0, 0, 0,  0, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t1_hold_7",      0, 0, 0, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t1_hold_8",      0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t1_wait_20",     0, 0, 0, 0, 20, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t1_lock_18",     0, 1, 0, 0, 18, 0, 0, 0, 0, 2));
        vecs.push_back(mk("t1_lock_19",     0, 1, 0, 0,  1, 0, 1, 0, 0, 3));
        vecs.push_back(mk("t1_ready_hold",  0, 1, 0, 0, 30, 0, 1, 0, 0, 3));
        // No lock: three timeouts then FAIL; FAIL ignores lock.
        vecs.push_back(mk("t2_hold",        1, 0, 0, 0,  8, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t2_wait_63",     0, 0, 0, 0, 63, 0, 0, 0, 0, 1));
        vecs.push_back(mk("t2_timeout_1",   0, 0, 0, 0,  1, 1, 0, 0, 1, 0));
        vecs.push_back(mk("t2_hold_2",      0, 0, 0, 0,  8, 0, 0, 0, 1, 1));
        vecs.push_back(mk("t2_timeout_2",   0, 0, 0, 0, 64, 1, 0, 0, 2, 0));
        vecs.push_back(mk("t2_hold_3",      0, 0, 0, 0,  8, 0, 0, 0, 2, 1));
        vecs.push_back(mk("t2_wait_63b",    0, 0, 0, 0, 63, 0, 0, 0, 2, 1));
        vecs.push_back(mk("t2_fail",        0, 0, 0, 0,  1, 1, 0, 1, 3, 4));
        vecs.push_back(mk("t2_fail_lock",   0, 1, 0, 0, 20, 1, 0, 1, 3, 4));
        vecs.push_back(mk("t2_req",         0, 0, 0, 1,  1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t2_req_hold_7",  0, 0, 0, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t2_req_hold_8",  0, 0, 0, 0,  1, 0, 0, 0, 0, 1));
        // Request held several cycles keeps the counter at 0.
        vecs.push_back(mk("t2_req_long",    0, 0, 0, 1,  5, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t2_req_long_7",  0, 0, 0, 0,  7, 1, 0, 0, 0, 0));
        vecs.push_back(mk("t2_req_long_8",  0, 0, 0, 0,  1, 0, 0, 0, 0, 1));

        foreach (vecs[i]) begin
            if (vecs[i].do_reset) apply_reset(vecs[i].lock, vecs[i].lost);
            qpll0_lock       = vecs[i].lock;
            qpll0_refclklost = vecs[i].lost;
            pll_reset_req    = vecs[i].req;
            sb_push(vecs[i].name, vecs[i].e_rst, vecs[i].e_rdy, vecs[i].e_fail,
                    vecs[i].e_retry, vecs[i].e_state);
            tick(vecs[i].cycles);
            sb_pop_check();
        end
        pll_reset_req = 1'b0;

        // Lock glitch at stable count 10: back to WAIT_LOCK, full window again.
        apply_reset(1'b0, 1'b0);
        step_expect("t3_wait", 8, 0, 0, 0, 0, 1);
        rise0 = rst_rises;
        qpll0_lock = 1'b1;
        step_expect("t3_stable_10", 13, 0, 0, 0, 0, 2);
        qpll0_lock = 1'b0;
        step_expect("t3_glitch_wait", 3, 0, 0, 0, 0, 1);
        qpll0_lock = 1'b1;
        step_expect("t3_not_ready", 18, 0, 0, 0, 0, 2);
        step_expect("t3_ready", 1, 0, 1, 0, 0, 3);
        check("t3_extra_reset_pulses", rst_rises - rise0, 0);

        // Loss in READY with a nonzero retry count: fresh sequence.
        apply_reset(1'b0, 1'b0);
        step_expect("t4_timeout", 72, 1, 0, 0, 1, 0);
        qpll0_lock = 1'b1;
        step_expect("t4_stable", 24, 0, 0, 0, 1, 2);
        step_expect("t4_ready", 1, 0, 1, 0, 1, 3);
        qpll0_lock = 1'b0;
        step_expect("t4_drop_2", 2, 0, 1, 0, 1, 3);
        step_expect("t4_drop_3", 1, 1, 0, 0, 0, 0);
        qpll0_lock = 1'b1;
        step_expect("t4_relock_pre", 24, 0, 0, 0, 0, 2);
        step_expect("t4_relock", 1, 0, 1, 0, 0, 3);

        // Refclk lost from reset: reset held, then 8 + 2 sync cycles.
        apply_reset(1'b0, 1'b1);
        low_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            if (qpll0_reset !== 1'b1) low_cycles++;
        end
        check("t5_low_while_lost", low_cycles, 0);
        step_expect("t5_state_lost", 0, 1, 0, 0, 0, 0);
        qpll0_refclklost = 1'b0;
        cycles_until_reset_low(40, n);
        check("t5_cycles_after_release", n, 10);

        // Refclk lost in WAIT_LOCK: back to RST_ASSERT, retry kept.
        apply_reset(1'b0, 1'b0);
        step_expect("t5b_timeout", 72, 1, 0, 0, 1, 0);
        step_expect("t5b_wait", 18, 0, 0, 0, 1, 1);
        qpll0_refclklost = 1'b1;
        step_expect("t5b_lost", 3, 1, 0, 0, 1, 0);
        qpll0_refclklost = 1'b0;

        // reset_n mid-WAIT_LOCK with retry_count=1.
        apply_reset(1'b0, 1'b0);
        step_expect("t6_timeout", 72, 1, 0, 0, 1, 0);
        step_expect("t6_wait_40", 48, 0, 0, 0, 1, 1);
        reset_n = 1'b0;
        step_expect("t6_reset_edge", 1, 1, 0, 0, 0, 0);
        reset_n = 1'b1;
        cycles_until_reset_low(40, n);
        check("t6_hold_restart", n, 8);

        check("sb_leftover", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
